// File: rtl/modport_counter.sv
// Loadable up/down counter.
// A synchronous reset (rstn, active-high) overrides a parallel load, and a load overrides counting.
module modport_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] cnt;

    // The counter moves on every cycle that has neither a reset nor a load; it has no hold state.
    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= data_in;
        end else if (mode) begin
            cnt <= cnt + WIDTH'(1);
        end else begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign dout = cnt;

endmodule

// File: tb/tb_modport_counter.sv
// Self-checking bench for modport_counter.
// Uses directed vectors, an integer reference model compared every cycle, and a random run.
module tb_modport_counter;

    logic       clk;
    logic       rstn;
    logic       load;
    logic       mode;
    logic [3:0] data_in;
    logic [3:0] dout;

    int checks = 0;
    int fails  = 0;
    int mdl    = 0;
    bit mvalid = 1'b0;
    bit done   = 1'b0;

    modport_counter #(.WIDTH(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .load    (load),
        .mode    (mode),
        .data_in (data_in),
        .dout    (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the count is an integer kept in the range 0..15, with the same reset/load/count priority.
    always @(posedge clk) begin
        if (rstn === 1'b1) begin
            mdl    = 0;
            mvalid = 1'b1;
        end else if (load === 1'b1) begin
            mdl = int'(data_in);
        end else if (mode === 1'b1) begin
            mdl = (mdl + 1) % 16;
        end else begin
            mdl = (mdl + 15) % 16;
        end
    end

    // Compare dout against the model at every negedge once the first reset has been applied.
    always @(negedge clk) begin
        if (mvalid && !done) begin
            checks++;
            if (dout !== 4'(mdl)) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t dout=%h expected=%h", $time, dout, 4'(mdl));
            end
        end
    end

    task automatic step(input logic r, input logic l, input logic m,
                        input logic [3:0] d, input logic [3:0] exp, input string name);
        rstn    = r;
        load    = l;
        mode    = m;
        data_in = d;
        @(posedge clk);
        #1;
        checks++;
        if (dout !== exp) begin
            fails++;
            $display("FAIL %s dout=%h expected=%h", name, dout, exp);
        end
        checks++;
        if (4'(mdl) !== exp) begin
            fails++;
            $display("FAIL model_%s model=%h expected=%h", name, 4'(mdl), exp);
        end
    endtask

    initial begin
        rstn    = 1'b0;
        load    = 1'b0;
        mode    = 1'b0;
        data_in = 4'h0;

        // Reset held for 2 cycles while a load is also requested.
        step(1'b1, 1'b1, 1'b0, 4'hA, 4'h0, "rst0");
        step(1'b1, 1'b1, 1'b0, 4'hA, 4'h0, "rst1");
        // After reset release, the first count step moves up or down from 0.
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h1, "rel_up");
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, "rst2");
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, "rel_dn");
        // Load a value, then count up.
        step(1'b0, 1'b1, 1'b0, 4'h5, 4'h5, "load5");
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h6, "up6");
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h7, "up7");
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h8, "up8");
        // Wrap upward; mode is ignored on the load cycle.
        step(1'b0, 1'b1, 1'b0, 4'hE, 4'hE, "loadE");
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'hF, "upF");
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, "upwrap0");
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h1, "upwrap1");
        // Wrap downward.
        step(1'b0, 1'b1, 1'b1, 4'h1, 4'h1, "load1");
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, "dn0");
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, "dnwrapF");
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'hE, "dnwrapE");
        // Priority: reset beats load on the same edge, then the load takes effect.
        step(1'b1, 1'b1, 1'b1, 4'h9, 4'h0, "prio_rst");
        step(1'b0, 1'b1, 1'b0, 4'h9, 4'h9, "prio_load");
        // Direction switches in the middle of a run.
        step(1'b0, 1'b1, 1'b0, 4'h3, 4'h3, "load3");
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h4, "dir_a");
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h5, "dir_b");
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h4, "dir_c");
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h3, "dir_d");
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h4, "dir_e");

        // Random traffic, checked by the per-cycle compare against the model.
        for (int i = 0; i < 1000; i++) begin
            rstn    = ($urandom_range(0, 15) == 0);
            load    = ($urandom_range(0, 3) == 0);
            mode    = 1'($urandom_range(0, 1));
            data_in = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
